// File: rtl/servo_pkg.sv
// ----------------------------------------------------------------------------
// servo_pkg
// Definitions shared by the servo sequencer and its settle timer:
//   estado_t            - sequencer FSM state encoding (2 bits)
//   TEMPO_ESPERA_PADRAO - default settle time per move, in clock cycles
//                         (0.5 s at 50 MHz)
//   POS_0 / POS_1       - position codes; each one selects the matching
//                         PWM pulse width
// ----------------------------------------------------------------------------
package servo_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,  // idle, ready to accept a request
    APLICA = 2'd1,  // write the new width to the addressed channel
    ESPERA = 2'd2,  // let the servo settle
    FIM    = 2'd3   // signal completion
  } estado_t;

  localparam int TEMPO_ESPERA_PADRAO = 25000000;

  localparam logic POS_0 = 1'b0;
  localparam logic POS_1 = 1'b1;

endpackage

// File: rtl/sequenciador_servos_temporizador.sv
// ----------------------------------------------------------------------------
// temporizador_servo
// A 32-bit settle counter. The count is cleared by limpa and advances by one
// on every cycle where conta is high. fim_tempo is high while the count
// equals TEMPO_ESPERA-1, which is the last cycle of the settle window.
//
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous, active-high; clears the count
//   limpa     - clear the count to 0 (this takes priority over conta)
//   conta     - advance the count by one
//   fim_tempo - the count has reached TEMPO_ESPERA-1
// ----------------------------------------------------------------------------
module temporizador_servo
  import servo_pkg::*;
#(
  parameter int TEMPO_ESPERA = TEMPO_ESPERA_PADRAO
) (
  input  logic clock,
  input  logic reset,
  input  logic limpa,
  input  logic conta,
  output logic fim_tempo
);

  localparam logic [31:0] ULTIMO = 32'(TEMPO_ESPERA - 1);

  logic [31:0] contador_q;
  logic [31:0] contador_d;

  always_comb begin
    // NOTE: give every signal a default value before any branch, so that no
    // path can leave it unassigned (an unassigned path would infer a latch).
    contador_d = contador_q;
    if (limpa) begin
      contador_d = '0;
    end else if (conta) begin
      contador_d = contador_q + 32'd1;
    end
  end

  // NOTE: use non-blocking assignments for state, so that every flop samples
  // the values from before the clock edge, whatever order the blocks run in.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contador_q <= '0;
    end else begin
      contador_q <= contador_d;
    end
  end

  // The sequencer leaves ESPERA on this cycle, so the count stops at most one
  // step past ULTIMO. It never wraps within a move.
  assign fim_tempo = (contador_q == ULTIMO);

endmodule

// File: rtl/sequenciador_servos.sv
// ----------------------------------------------------------------------------
// sequenciador_servos
// Accepts one move request at a time. A move sets largura[servo_id] to
// posicao, waits TEMPO_ESPERA cycles for the servo to settle, then pulses fim.
// A request for a channel that does not exist is rejected with a one-cycle
// erro pulse.
//
// Optional feature: when the macro SERVO_PULA_IGUAL_EN is defined, a request
// that asks for the width the channel already has skips the write and the
// settle wait, and goes straight to FIM.
//
// Ports:
//   clock    - system clock, rising edge
//   reset    - asynchronous, active-high
//   iniciar  - move-request strobe; it is sampled only while idle
//   servo_id - target channel
//   posicao  - requested position code (POS_0 / POS_1)
//   largura  - width select; bit i drives PWM channel i
//   pronto   - high while idle (a request seen in this cycle is accepted)
//   fim      - one-cycle pulse when a move completes
//   erro     - one-cycle pulse when a servo_id is rejected as out of range
// ----------------------------------------------------------------------------
module sequenciador_servos
  import servo_pkg::*;
#(
  parameter  int N_SERVOS     = 4,
  parameter  int TEMPO_ESPERA = TEMPO_ESPERA_PADRAO,
  localparam int ID_W         = (N_SERVOS > 1) ? $clog2(N_SERVOS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                iniciar,
  input  logic [ID_W-1:0]     servo_id,
  input  logic                posicao,
  output logic [N_SERVOS-1:0] largura,
  output logic                pronto,
  output logic                fim,
  output logic                erro
);

  estado_t             estado_q,  estado_d;
  logic [ID_W-1:0]     servo_q,   servo_d;
  logic                pos_q,     pos_d;
  logic [N_SERVOS-1:0] largura_q, largura_d;
  logic                pronto_q,  pronto_d;
  logic                fim_q,     fim_d;
  logic                erro_q,    erro_d;

  logic limpa;
  logic conta;
  logic fim_tempo;
  logic id_valido;

  assign id_valido = (32'(servo_id) < 32'(N_SERVOS));

  temporizador_servo #(
    .TEMPO_ESPERA (TEMPO_ESPERA)
  ) u_temporizador (
    .clock     (clock),
    .reset     (reset),
    .limpa     (limpa),
    .conta     (conta),
    .fim_tempo (fim_tempo)
  );

  always_comb begin
    estado_d  = estado_q;
    servo_d   = servo_q;
    pos_d     = pos_q;
    largura_d = largura_q;
    fim_d     = 1'b0;
    erro_d    = 1'b0;
    limpa     = 1'b0;
    conta     = 1'b0;

    unique case (estado_q)
      OCIOSO: begin
        if (iniciar) begin
          if (id_valido) begin
            servo_d  = servo_id;
            pos_d    = posicao;
`ifdef SERVO_PULA_IGUAL_EN
            // The channel already has the requested width, so go straight
            // to completion.
            estado_d = (posicao == largura_q[servo_id]) ? FIM : APLICA;
`else
            estado_d = APLICA;
`endif
          end else begin
            erro_d = 1'b1;
          end
        end
      end
      APLICA: begin
        largura_d[servo_q] = pos_q;
        limpa              = 1'b1;
        estado_d           = ESPERA;
      end
      ESPERA: begin
        conta = 1'b1;
        if (fim_tempo) begin
          estado_d = FIM;
        end
      end
      FIM: begin
        fim_d    = 1'b1;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase

    // The ready flag follows the next state, so it is registered and still
    // matches the state for every cycle.
    pronto_d = (estado_d == OCIOSO);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      servo_q   <= '0;
      pos_q     <= 1'b0;
      largura_q <= '0;
      pronto_q  <= 1'b1;
      fim_q     <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      servo_q   <= servo_d;
      pos_q     <= pos_d;
      largura_q <= largura_d;
      pronto_q  <= pronto_d;
      fim_q     <= fim_d;
      erro_q    <= erro_d;
    end
  end

  assign largura = largura_q;
  assign pronto  = pronto_q;
  assign fim     = fim_q;
  assign erro    = erro_q;

endmodule
